// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide req/ack data bus between the access stage and memory
interface mem_access_unit_if;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memWData;
    logic        memAck;
    logic [31:0] memRData;
    modport master (output memReq, memWe, memAddr, memByteEn, memWData, input memAck, memRData);
    modport slave (input memReq, memWe, memAddr, memByteEn, memWData, output memAck, memRData);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle LB/LW/SB/SW access stage with req/ack bus, timeout and stall output
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic [31:0] memoryOut,
    output logic        busy,
    output logic        done,
    output logic        error,
    mem_access_unit_if.master bus
);
    localparam logic [5:0] OPC_LB = 6'h20;
    localparam logic [5:0] OPC_LW = 6'h23;
    localparam logic [5:0] OPC_SB = 6'h28;
    localparam logic [5:0] OPC_SW = 6'h2b;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state_q, state_d;
    logic [31:0] out_q, out_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0] be_q, be_d;
    logic req_q, req_d, we_q, we_d, done_q, done_d, error_q, error_d, byte_q, byte_d;
    logic [1:0] lane_q, lane_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0] opc;
    logic is_word, is_store, is_mem, accept, timeout;
    logic [7:0] rbyte;
    always_comb begin
        opc = instruction[31:26];
        is_word = opc == OPC_LW || opc == OPC_SW;
        is_store = opc == OPC_SB || opc == OPC_SW;
        is_mem = is_word || opc == OPC_LB || opc == OPC_SB;
        accept = state_q == IDLE && start && is_mem && (!is_word || address[1:0] == 2'b00);
        timeout = TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
        // lane 0 is the most significant byte, so ~lane selects the byte offset
        rbyte = bus.memRData[{~lane_q, 3'b000} +: 8];
        state_d = state_q;
        out_d = out_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        be_d = be_q;
        req_d = req_q;
        we_d = we_q;
        byte_d = byte_q;
        lane_d = lane_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = REQ;
                req_d = 1'b1;
                we_d = is_store;
                addr_d = {address[31:2], 2'b00};
                be_d = is_word ? 4'b1111 : 4'b1000 >> address[1:0];
                wdata_d = !is_store ? 32'h0 : is_word ? storeData : {4{storeData[7:0]}};
                byte_d = !is_word;
                lane_d = address[1:0];
                cnt_d = '0;
            end else if (start) begin
                state_d = DONE;
                done_d = 1'b1;
                error_d = is_mem;
            end
            REQ: if (bus.memAck || timeout) begin
                state_d = DONE;
                req_d = 1'b0;
                cnt_d = '0;
                done_d = 1'b1;
                error_d = !bus.memAck;
                out_d = bus.memAck && !we_q ? (byte_q ? {{24{rbyte[7]}}, rbyte} : bus.memRData) : out_q;
            end else cnt_d = cnt_q + CNT_W'(1);
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            be_q <= '0;
            req_q <= 1'b0;
            we_q <= 1'b0;
            byte_q <= 1'b0;
            lane_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q <= out_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            be_q <= be_d;
            req_q <= req_d;
            we_q <= we_d;
            byte_q <= byte_d;
            lane_q <= lane_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            error_q <= error_d;
        end
    end
    assign memoryOut = out_q;
    assign done = done_q;
    assign error = error_q;
    assign busy = accept || state_q == REQ;
    assign bus.memReq = req_q;
    assign bus.memWe = we_q;
    assign bus.memAddr = addr_q;
    assign bus.memByteEn = be_q;
    assign bus.memWData = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: transaction-level model predicts every cycle's outputs; directed and random accesses
module tb_mem_access_unit;
    localparam int TO = 4;
    localparam logic [5:0] LB = 6'h20, LW = 6'h23, SB = 6'h28, SW = 6'h2b, ADDU = 6'h00, LUI = 6'h0f;
    typedef struct packed {
        logic        busy;
        logic        req;
        logic        done;
        logic        err;
        logic [31:0] mout;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [31:0] instruction = '0, address = '0, storeData = '0, memoryOut;
    logic busy, done, error;
    mem_access_unit_if bus();
    mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction), .address(address),
        .storeData(storeData), .memoryOut(memoryOut), .busy(busy), .done(done), .error(error),
        .bus(bus.master)
    );
    always #5 clk = ~clk;
    exp_t exp_q[$];
    string lit_n[$];
    logic [31:0] lit_a[$], lit_e[$];
    int n_vec = 0, n_bad = 0;
    logic [31:0] mout_m = '0;
    exp_t bus_e = '0;
    logic snap_busy, snap_we, snap_done, snap_err;
    logic [31:0] snap_addr, snap_wd;
    logic [3:0] snap_be;
    int req_cycles;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        while (lit_n.size() > 0) chk(lit_n.pop_front(), lit_a.pop_front(), lit_e.pop_front());
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("memReq", 32'(bus.memReq), 32'(e.req));
            chk("done", 32'(done), 32'(e.done));
            chk("error", 32'(error), 32'(e.err));
            chk("memoryOut", memoryOut, e.mout);
            if (e.req) begin
                chk("memWe", 32'(bus.memWe), 32'(e.we));
                chk("memAddr", bus.memAddr, e.addr);
                chk("memByteEn", 32'(bus.memByteEn), 32'(e.be));
                chk("memWData", bus.memWData, e.wd);
            end
        end
    end
    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_n.push_back(n);
        lit_a.push_back(a);
        lit_e.push_back(e);
    endtask
    task automatic push(input logic bz, input logic rq, input logic dn, input logic er);
        exp_t e;
        e = bus_e;
        e.busy = bz;
        e.req = rq;
        e.done = dn;
        e.err = er;
        e.mout = mout_m;
        exp_q.push_back(e);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic noise();
        instruction = $urandom;
        address = $urandom;
        storeData = $urandom;
        bus.memAck = 1'($urandom);
        bus.memRData = $urandom;
    endtask
    task automatic idle_cycle();
        step();
        noise();
        start = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    // ack_at: REQ cycle (1-based) carrying memAck; beyond TO means the access times out
    task automatic txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int ack_at, input int kill);
        bit mem, word, st, ok, acked;
        int n, sb;
        logic [7:0] b;
        logic er;
        mem = op inside {LB, LW, SB, SW};
        word = op == LW || op == SW;
        st = op == SB || op == SW;
        ok = mem && (!word || a[1:0] == 2'b00);
        bus_e.we = st;
        bus_e.addr = a & 32'hffff_fffc;
        bus_e.be = word ? 4'hf : 4'(1 << (3 - int'(a[1:0])));
        bus_e.wd = !st ? 32'h0 : word ? sd : sd[7:0] * 32'h0101_0101;
        req_cycles = 0;
        step();
        noise();
        start = 1'b1;
        instruction = {op, 26'($urandom)};
        address = a;
        storeData = sd;
        push(ok, 1'b0, 1'b0, 1'b0);
        #2 snap_busy = busy;
        er = mem;
        if (ok) begin
            acked = ack_at <= TO;
            n = acked ? ack_at : TO;
            for (int j = 1; j <= n; j++) begin
                step();
                noise();
                start = 1'($urandom);
                bus.memAck = j == ack_at;
                if (j == ack_at) bus.memRData = rd;
                push(1'b1, 1'b1, 1'b0, 1'b0);
                #2;
                if (bus.memReq) req_cycles++;
                if (j == 1) begin
                    snap_we = bus.memWe;
                    snap_addr = bus.memAddr;
                    snap_be = bus.memByteEn;
                    snap_wd = bus.memWData;
                end
                if (j == kill) begin
                    start = 1'b0;
                    @(negedge clk);
                    #1 reset = 1'b1;
                    #1;
                    lit("rst_async_memReq", 32'(bus.memReq), 0);
                    lit("rst_async_busy", 32'(busy), 0);
                    lit("rst_async_done", 32'(done), 0);
                    step();
                    lit("rst_done", 32'(done), 0);
                    lit("rst_memoryOut", memoryOut, 0);
                    lit("rst_memReq", 32'(bus.memReq), 0);
                    reset = 1'b0;
                    mout_m = '0;
                    return;
                end
            end
            if (acked && !st) begin
                b = 8'(rd >> (8 * (3 - int'(a[1:0]))));
                sb = int'($signed(b));
                mout_m = word ? rd : 32'(sb);
            end
            er = !acked;
        end
        step();
        noise();
        start = 1'($urandom);
        push(1'b0, 1'b0, 1'b1, er);
        #2;
        snap_done = done;
        snap_err = error;
    endtask
    initial begin
        bus.memAck = 1'b0;
        bus.memRData = '0;
        #2;
        lit("reset_memoryOut", memoryOut, 0);
        lit("reset_done", 32'(done), 0);
        lit("reset_error", 32'(error), 0);
        lit("reset_busy", 32'(busy), 0);
        lit("reset_memReq", 32'(bus.memReq), 0);
        lit("reset_memWe", 32'(bus.memWe), 0);
        lit("reset_memAddr", bus.memAddr, 0);
        lit("reset_memByteEn", 32'(bus.memByteEn), 0);
        lit("reset_memWData", bus.memWData, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        txn(LW, 32'h100, 32'h0, 32'hdeadbeef, 1, 0);
        lit("lw_busy", 32'(snap_busy), 1);
        lit("lw_addr", snap_addr, 32'h100);
        lit("lw_we", 32'(snap_we), 0);
        lit("lw_be", 32'(snap_be), 32'hf);
        lit("lw_done", 32'(snap_done), 1);
        lit("lw_out", memoryOut, 32'hdeadbeef);
        txn(LB, 32'h103, 32'h0, 32'h123456f0, 1, 0);
        lit("lb3_be", 32'(snap_be), 32'h1);
        lit("lb3_out", memoryOut, 32'hfffffff0);
        txn(LB, 32'h101, 32'h0, 32'h123456f0, 1, 0);
        lit("lb1_be", 32'(snap_be), 32'h4);
        lit("lb1_out", memoryOut, 32'h00000034);
        txn(SB, 32'h202, 32'haabbcc5a, 32'h0, 4, 0);
        lit("sb_we", 32'(snap_we), 1);
        lit("sb_be", 32'(snap_be), 32'h2);
        lit("sb_wd", snap_wd, 32'h5a5a5a5a);
        lit("sb_req_cycles", 32'(req_cycles), 4);
        lit("sb_err", 32'(snap_err), 0);
        txn(SW, 32'h006, 32'h11223344, 32'h0, 1, 0);
        lit("sw_mis_busy", 32'(snap_busy), 0);
        lit("sw_mis_done", 32'(snap_done), 1);
        lit("sw_mis_err", 32'(snap_err), 1);
        txn(ADDU, 32'h0, 32'h0, 32'h0, 1, 0);
        lit("addu_err", 32'(snap_err), 0);
        lit("addu_out", memoryOut, 32'h34);
        txn(LW, 32'h300, 32'h0, 32'h55555555, 99, 0);
        lit("to_req_cycles", 32'(req_cycles), 4);
        lit("to_err", 32'(snap_err), 1);
        lit("to_out", memoryOut, 32'h34);
        txn(LW, 32'h300, 32'h0, 32'h66666666, 4, 0);
        lit("to_ack_err", 32'(snap_err), 0);
        lit("to_ack_out", memoryOut, 32'h66666666);
        txn(LW, 32'h400, 32'h0, 32'h77777777, 3, 2);
        repeat (3) idle_cycle();
        txn(LW, 32'h500, 32'h0, 32'hcafef00d, 2, 0);
        lit("post_rst_out", memoryOut, 32'hcafef00d);
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [31:0] a;
            int k;
            k = $urandom_range(0, 5);
            op = k == 0 ? LB : k == 1 ? LW : k == 2 ? SB : k == 3 ? SW : k == 4 ? ADDU : LUI;
            a = $urandom;
            if ((op == LW || op == SW) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            txn(op, a, $urandom, $urandom, $urandom_range(1, 6), 0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        repeat (3) idle_cycle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
